// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator MMIO controller: opcodes, register map, FSM states.
package accel_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_MOD    = 3'b010,
    OP_RSETUP = 3'b011,
    OP_MULT   = 3'b100,
    OP_EXP    = 3'b101
  } opcode_e;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_MOD    = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_RESULT = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  // Opcodes 110/111 have no accelerator function behind them.
  function automatic logic op_reserved(input logic [2:0] op);
    return op > OP_EXP;
  endfunction

  // Montgomery-domain ops need a completed R setup and an odd modulus.
  function automatic logic op_needs_r(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_EXP);
  endfunction

endpackage

// File: rtl/accel_mmio_ctrl.sv
// Register-mapped front end that launches one accelerator operation at a time.
// Optional build macro ACCEL_WATCHDOG_EN adds a WAIT-state timeout.
module accel_mmio_ctrl
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic [DATA_WIDTH-1:0] acc_mod,
  output logic [2:0]            acc_control,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_result,
  input  logic                  acc_finished,
  output logic                  irq
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, mod_reg, result_reg;
  logic [2:0]            control_reg;
  logic                  start_reg, irq_reg, done_reg, err_reg, r_ready_reg;

  logic       go_write;
  logic [2:0] go_op;
  logic       go_rejected;
  logic       busy;

  assign go_write    = we && (addr == ADDR_CTRL) && wdata[3];
  assign go_op       = wdata[2:0];
  assign go_rejected = op_reserved(go_op) ||
                       (op_needs_r(go_op) && (!r_ready_reg || !mod_reg[0]));
  assign busy        = (state_reg == ST_START) || (state_reg == ST_WAIT);

`ifdef ACCEL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      mod_reg     <= '0;
      control_reg <= '0;
      result_reg  <= '0;
      start_reg   <= 1'b0;
      irq_reg     <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      r_ready_reg <= 1'b0;
`ifdef ACCEL_WATCHDOG_EN
      wdog_cnt_reg <= '0;
`endif
    end else begin
      irq_reg   <= 1'b0;
      start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (we) begin
            case (addr)
              ADDR_A:   a_reg <= wdata[DATA_WIDTH-1:0];
              ADDR_B:   b_reg <= wdata[DATA_WIDTH-1:0];
              ADDR_MOD: begin
                mod_reg     <= wdata[DATA_WIDTH-1:0];
                r_ready_reg <= 1'b0;
              end
              default: ;
            endcase
          end
          // acc_finished is deliberately not looked at here.
          if (go_write) begin
            if (go_rejected) begin
              err_reg <= 1'b1;
              irq_reg <= 1'b1;
            end else begin
              control_reg <= go_op;
              done_reg    <= 1'b0;
              err_reg     <= 1'b0;
              start_reg   <= 1'b1;
              state_reg   <= ST_START;
            end
          end
        end
        ST_START: begin
          // Combinational ops already show finished here; wait one cycle before sampling.
          state_reg <= ST_WAIT;
`ifdef ACCEL_WATCHDOG_EN
          wdog_cnt_reg <= '0;
`endif
        end
        ST_WAIT: begin
          if (acc_finished) begin
            result_reg <= acc_result;
            done_reg   <= 1'b1;
            irq_reg    <= 1'b1;
            state_reg  <= ST_IDLE;
            if (control_reg == OP_RSETUP) r_ready_reg <= 1'b1;
          end
`ifdef ACCEL_WATCHDOG_EN
          else if (wdog_cnt_reg == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
            err_reg   <= 1'b1;
            irq_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_A:      rdata[DATA_WIDTH-1:0] = a_reg;
      ADDR_B:      rdata[DATA_WIDTH-1:0] = b_reg;
      ADDR_MOD:    rdata[DATA_WIDTH-1:0] = mod_reg;
      ADDR_CTRL:   rdata[2:0]            = control_reg;
      ADDR_STATUS: rdata[3:0]            = {r_ready_reg, err_reg, done_reg, busy};
      ADDR_RESULT: rdata[DATA_WIDTH-1:0] = result_reg;
      default: ;
    endcase
  end

  assign acc_a       = a_reg;
  assign acc_b       = b_reg;
  assign acc_mod     = mod_reg;
  assign acc_control = control_reg;
  assign acc_start   = start_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_accel_mmio_ctrl.sv
// Directed and randomized bench for accel_mmio_ctrl; the accelerator is played by the bench.
module tb_accel_mmio_ctrl;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        reset, we, acc_start, acc_finished, irq;
  logic [2:0]  addr, acc_control;
  logic [31:0] wdata, rdata;
  logic [7:0]  acc_a, acc_b, acc_mod, acc_result;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  // Reference state of the register file, tracked from the rules only.
  logic [7:0] m_a, m_b, m_mod, m_result;
  logic       m_done, m_err, m_rready;

  accel_mmio_ctrl #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .acc_a(acc_a), .acc_b(acc_b), .acc_mod(acc_mod), .acc_control(acc_control),
    .acc_start(acc_start), .acc_result(acc_result), .acc_finished(acc_finished),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (acc_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick;
    we = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic busy);
    logic [31:0] v;
    rd(ADDR_STATUS, v);
    chk(tag, v, {28'b0, m_rready, m_err, m_done, busy});
  endtask

  task automatic chk_regs(input string tag);
    logic [31:0] v;
    chk({tag, "_a"}, acc_a, m_a);
    chk({tag, "_b"}, acc_b, m_b);
    chk({tag, "_mod"}, acc_mod, m_mod);
    rd(ADDR_RESULT, v);
    chk({tag, "_result"}, v, m_result);
    rd(ADDR_A, v);
    chk({tag, "_rd_a"}, v, m_a);
    rd(3'd7, v);
    chk({tag, "_unmapped"}, v, 0);
    chk_status({tag, "_status"}, 1'b0);
  endtask

  task automatic model_reset;
    m_a = 0; m_b = 0; m_mod = 0; m_result = 0;
    m_done = 0; m_err = 0; m_rready = 0;
  endtask

  task automatic set_operand(input logic [2:0] a, input logic [7:0] v);
    wr(a, {24'b0, v});
    case (a)
      ADDR_A:   m_a = v;
      ADDR_B:   m_b = v;
      default: begin m_mod = v; m_rready = 0; end
    endcase
  endtask

  // Go-write followed by the accelerator answering after `delay` WAIT cycles.
  // With `early`, finished is raised with a wrong value during the go cycle and START.
  task automatic go(input logic [2:0] op, input int delay, input logic [7:0] res, input bit early);
    int s0;
    bit rej;
    logic [31:0] v;
    s0  = start_cnt;
    rej = (op >= 3'd6) || ((op == 3'd4 || op == 3'd5) && (!m_rready || !m_mod[0]));
    if (early) begin acc_finished = 1'b1; acc_result = ~res; end
    wr(ADDR_CTRL, {28'b0, 1'b1, op});
    if (rej) begin
      m_err = 1;
      chk("rej_irq", irq, 1);
      chk_status("rej_status", 1'b0);
      acc_finished = 1'b0;
      tick; tick;
      chk("rej_no_start", start_cnt, s0);
      chk("rej_irq_once", irq, 0);
    end else begin
      m_done = 0; m_err = 0;
      chk("go_start", acc_start, 1);
      chk("go_ctrl", acc_control, op);
      chk("go_irq_low", irq, 0);
      chk_status("start_busy", 1'b1);
      tick;
      acc_finished = 1'b0;
      chk("start_one_cycle", acc_start, 0);
      for (int i = 0; i < delay; i++) begin
        chk_status("wait_busy", 1'b1);
        tick;
      end
      acc_finished = 1'b1; acc_result = res;
      tick;
      acc_finished = 1'b0; acc_result = 8'($urandom);
      m_done = 1; m_result = res;
      if (op == 3'd3) m_rready = 1;
      chk("done_irq", irq, 1);
      rd(ADDR_RESULT, v);
      chk("done_result", v, m_result);
      chk_status("done_status", 1'b0);
      tick;
      chk("irq_pulse_end", irq, 0);
      chk("one_start", start_cnt, s0 + 1);
    end
  endtask

  initial begin
    logic [31:0] v;
    int s0;
    we = 0; addr = 0; wdata = 0; acc_finished = 0; acc_result = 0; reset = 1;
    tick; tick;
    reset = 0;
    model_reset;

    chk("rst_ctrl", acc_control, 0);
    chk("rst_start", acc_start, 0);
    chk("rst_irq", irq, 0);
    chk_regs("rst");

    // Modular add: (200 + 100) mod 251.
    set_operand(ADDR_A, 8'd200);
    set_operand(ADDR_B, 8'd100);
    set_operand(ADDR_MOD, 8'd251);
    go(3'd0, 0, 8'((200 + 100) % 251), 1'b0);
    chk_regs("add");

    // Slow accelerator: busy for all nine waiting cycles.
    set_operand(ADDR_A, 8'h01);
    set_operand(ADDR_B, 8'h00);
    go(3'd2, 9, 8'd5, 1'b0);

    // finished already high in the go cycle and START must not be captured.
    go(3'd1, 0, 8'h3C, 1'b1);

    // R setup then exponent 3^5 mod 7.
    set_operand(ADDR_MOD, 8'd7);
    go(3'd3, 2, 8'd2, 1'b0);
    chk_status("rready_set", 1'b0);
    set_operand(ADDR_A, 8'd3);
    set_operand(ADDR_B, 8'd5);
    go(3'd5, 4, 8'((3 * 3 * 3 * 3 * 3) % 7), 1'b0);

    // New MOD drops r_ready; even MOD blocks exp even after setup; reserved op.
    set_operand(ADDR_MOD, 8'd7);
    go(3'd4, 0, 8'h00, 1'b0);
    set_operand(ADDR_MOD, 8'd8);
    go(3'd3, 1, 8'd4, 1'b0);
    go(3'd5, 0, 8'h00, 1'b0);
    go(3'd6, 0, 8'h00, 1'b0);
    chk_regs("reject");

    // Writes while busy are dropped; reset in WAIT aborts and ignores a late finish.
    s0 = start_cnt;
    wr(ADDR_CTRL, 32'h8);
    m_done = 0; m_err = 0;
    tick;
    wr(ADDR_A, 32'h55);
    wr(ADDR_CTRL, 32'h9);
    chk("busy_a", acc_a, m_a);
    chk("busy_ctrl", acc_control, 0);
    chk("busy_starts", start_cnt, s0 + 1);
    chk_status("busy_status", 1'b1);
    reset = 1;
    tick;
    reset = 0;
    model_reset;
    acc_finished = 1; acc_result = 8'hAA;
    tick;
    acc_finished = 0;
    chk("late_irq", irq, 0);
    chk_regs("abort");

`ifdef ACCEL_WATCHDOG_EN
    set_operand(ADDR_RESULT, 8'h00);
    wr(ADDR_CTRL, 32'h8);
    tick;
    repeat (15) tick;
    chk_status("wdog_still_busy", 1'b1);
    tick;
    m_err = 1;
    chk("wdog_irq", irq, 1);
    chk_regs("wdog");
`endif

    for (int n = 0; n < 25; n++) begin
      logic [7:0] val;
      val = 8'($urandom);
      case ($urandom_range(0, 3))
        0: set_operand(ADDR_A, val);
        1: set_operand(ADDR_B, val);
        2: set_operand(ADDR_MOD, val | 8'($urandom_range(0, 1)));
        default: ;
      endcase
      go(3'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 8'($urandom),
         1'($urandom_range(0, 1)));
      chk_regs("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accel_mmio_ctrl.md
ACCEL_MMIO_CTRL -- requirements
Module: accel_mmio_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, as the operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, as the watchdog limit (used only under REQ-030).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  bus write strobe, one write per cycle.
REQ-006 addr  input  3  word register select: 0 A, 1 B, 2 MOD, 3 CTRL, 4 STATUS, 5 RESULT.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  combinational read of the register at addr; zero-extended; unmapped addresses read 0.
REQ-009 acc_a, acc_b, acc_mod  output  DATA_WIDTH  registered operands to the accelerator.
REQ-010 acc_control  output  3  registered opcode: 000 add, 001 sub, 010 mod, 011 R setup, 100 mult, 101 exp.
REQ-011 acc_start  output  1  one-cycle start pulse.
REQ-012 acc_result  input  DATA_WIDTH  and acc_finished  input  1  are the accelerator's result and completion flag.
REQ-013 irq  output  1  high for one cycle when an operation completes or errors.

Function
REQ-014 FSM SHALL have states IDLE, START, WAIT; reset state IDLE.
REQ-015 Writes to A, B, MOD SHALL take effect only in IDLE; writes in START/WAIT are ignored.
REQ-016 A write to MOD SHALL clear r_ready.
REQ-017 A CTRL write in IDLE with wdata[3]=1 (go) SHALL latch wdata[2:0] into acc_control, clear done and err, and move to START, unless REQ-018 rejects it.
REQ-018 Go with opcode 100/101 while r_ready=0 or acc_mod[0]=0, or with opcode 110/111, SHALL set err, pulse irq, and remain in IDLE without asserting acc_start.
REQ-019 START SHALL assert acc_start for exactly one cycle and move to WAIT.
REQ-020 acc_finished SHALL be sampled only in WAIT, never in START (combinational ops report finished immediately).
REQ-021 In WAIT with acc_finished=1: capture acc_result into RESULT, set done, pulse irq, return to IDLE; latency go-write cycle N -> done visible at N+3 minimum.
REQ-022 Completion of opcode 011 SHALL set r_ready; RESULT receives acc_result unchanged.
REQ-023 CTRL writes in START/WAIT SHALL be ignored (no queueing).
REQ-024 STATUS SHALL read {28'b0, r_ready, err, done, busy}; busy=1 in START and WAIT.
REQ-025 Reading RESULT or STATUS SHALL have no side effects.
REQ-026 Simultaneous go-write and acc_finished in IDLE: acc_finished SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE and zero acc_a, acc_b, acc_mod, acc_control, acc_start, RESULT, done, err, r_ready, irq, and the watchdog counter.
REQ-028 Reset mid-operation (START/WAIT) SHALL abort without capturing a result; a late acc_finished afterwards SHALL be ignored.
REQ-029 acc_mod SHALL reset to 0, so exp/mult are rejected until an odd MOD is written and R setup completes.

Configuration
REQ-030 With ACCEL_WATCHDOG_EN defined, a counter SHALL run in WAIT and, on reaching TIMEOUT_CYCLES without acc_finished, set err, pulse irq, and return to IDLE without updating RESULT; without it, WAIT waits indefinitely and the counter is absent.

Structure
REQ-031 A shared package accel_pkg SHALL hold the opcode enum, register address constants, and the FSM state typedef.
REQ-032 The design SHALL be a single module with no sub-modules; the accelerator is instantiated beside it at the top level.

Verification
REQ-033 A=200, B=100, MOD=251, go op 000 -> acc_start one cycle, done=1, RESULT=49, irq pulse.
REQ-034 A=0x01, B=0x00, MOD=251, go op 010, accelerator finishes after 9 cycles -> busy for the whole duration, RESULT=5.
REQ-035 MOD=7, go op 011, then A=3, B=5, go op 101 -> r_ready=1 after setup; RESULT=5.
REQ-036 MOD=7 write, go op 100 without R setup -> err=1, acc_start never asserted; then MOD=8, setup, go op 101 -> err=1.
REQ-037 Writes to A and a second go while busy -> acc_a unchanged, only one acc_start; reset in WAIT -> IDLE, RESULT=0.
REQ-038 ACCEL_WATCHDOG_EN with TIMEOUT_CYCLES=16, acc_finished held 0 -> err=1 at cycle 16 of WAIT, RESULT unchanged.
